// File: rtl/spi_flash_read_ctrl_if.sv
// Request/response bus between the fabric-side requester and the SPI flash read sequencer.
interface spi_flash_read_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [15:0] req_len;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        rsp_last;
  logic        done;
  logic        busy;

  modport master (
    output req_valid, req_addr, req_len, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_last, done, busy
  );

  modport slave (
    input  req_valid, req_addr, req_len, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_last, done, busy
  );
endinterface

// File: rtl/spi_flash_read_ctrl.sv
// Single-lane SPI mode-0 read sequencer (4-byte-address READ 0x13) for S25FS512S NOR flash.
// Returned bytes stream through a one-byte slot; a full slot stretches SCK high until it drains.
module spi_flash_read_ctrl #(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned CS_IDLE  = 4,
  parameter int unsigned RST_WAIT = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  spi_flash_read_ctrl_if.slave        bus,
  output logic                        spi_sck,
  output logic                        spi_cs_n,
  output logic                        spi_si,
  input  logic                        spi_so,
  output logic                        spi_wp_n,
  output logic                        spi_reset_n
);

  typedef enum logic [2:0] {
    StRstWait, StIdle, StCmd, StAddr, StData, StHold, StTail, StCsWait
  } state_e;

  localparam logic [15:0] DivLast     = 16'(CLK_DIV - 1);
  localparam logic [15:0] CsIdleLast  = 16'(CS_IDLE - 1);
  localparam logic [15:0] RstWaitLast = 16'(RST_WAIT - 1);
  localparam logic [7:0]  CmdRead4b   = 8'h13;

  state_e      r_state;
  logic [15:0] r_div;
  logic [15:0] r_bytes;
  logic [5:0]  r_bit;
  logic [39:0] r_tx;
  logic [7:0]  r_rx;
  logic        r_sck;
  logic        r_cs_n;
  logic        r_reset_n;
  logic        r_rsp_valid;
  logic [7:0]  r_rsp_data;
  logic        r_rsp_last;
  logic        r_done;

  logic       w_tick;
  logic       w_slot_free;
  logic [7:0] w_rx_next;

  assign w_tick      = (r_div == DivLast);
  assign w_slot_free = !r_rsp_valid || bus.rsp_ready;
  assign w_rx_next   = {r_rx[6:0], spi_so};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= StRstWait;
      r_div       <= '0;
      r_bytes     <= '0;
      r_bit       <= '0;
      r_tx        <= '0;
      r_rx        <= '0;
      r_sck       <= 1'b0;
      r_cs_n      <= 1'b1;
      r_reset_n   <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_last  <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_reset_n <= 1'b1;
      r_done    <= 1'b0;
      if (r_rsp_valid && bus.rsp_ready) r_rsp_valid <= 1'b0;

      unique case (r_state)
        StRstWait: begin
          r_div <= r_div + 16'd1;
          if (r_div == RstWaitLast) begin
            r_div   <= '0;
            r_state <= StIdle;
          end
        end
        StIdle: begin
          if (bus.req_valid) begin
            if (bus.req_len == '0) begin
              r_done <= 1'b1;
            end else begin
              r_tx    <= {CmdRead4b, bus.req_addr};
              r_bytes <= bus.req_len;
              r_cs_n  <= 1'b0;
              r_sck   <= 1'b0;
              r_div   <= '0;
              r_bit   <= '0;
              r_state <= StCmd;
            end
          end
        end
        StCmd, StAddr, StData: begin
          r_div <= r_div + 16'd1;
          if (w_tick) begin
            r_div <= '0;
            r_sck <= !r_sck;
            if (!r_sck) begin
              // Rising edge: sample SO; on the 8th data bit hand the byte to the slot or stall.
              r_rx <= w_rx_next;
              if (r_state == StData) begin
                if (r_bit == 6'd7) begin
                  r_bit <= '0;
                  if (w_slot_free) begin
                    r_rsp_valid <= 1'b1;
                    r_rsp_data  <= w_rx_next;
                    r_rsp_last  <= (r_bytes == 16'd1);
                    r_bytes     <= r_bytes - 16'd1;
                    if (r_bytes == 16'd1) r_state <= StTail;
                  end else begin
                    r_state <= StHold;
                  end
                end else begin
                  r_bit <= r_bit + 6'd1;
                end
              end
            end else begin
              r_tx <= {r_tx[38:0], 1'b0};
              if (r_state == StCmd) begin
                r_bit <= r_bit + 6'd1;
                if (r_bit == 6'd7) r_state <= StAddr;
              end else if (r_state == StAddr) begin
                if (r_bit == 6'd39) begin
                  r_bit   <= '0;
                  r_state <= StData;
                end else begin
                  r_bit <= r_bit + 6'd1;
                end
              end
            end
          end
        end
        StHold: begin
          if (w_slot_free) begin
            r_rsp_valid <= 1'b1;
            r_rsp_data  <= r_rx;
            r_rsp_last  <= (r_bytes == 16'd1);
            r_bytes     <= r_bytes - 16'd1;
            r_div       <= '0;
            r_state     <= (r_bytes == 16'd1) ? StTail : StData;
          end
        end
        StTail: begin
          r_div <= r_div + 16'd1;
          if (w_tick) begin
            r_div <= '0;
            if (r_sck) begin
              r_sck <= 1'b0;
            end else begin
              r_cs_n  <= 1'b1;
              r_state <= StCsWait;
            end
          end
        end
        StCsWait: begin
          r_div <= r_div + 16'd1;
          if (r_div == CsIdleLast) begin
            r_div   <= '0;
            r_done  <= 1'b1;
            r_state <= StIdle;
          end
        end
      endcase
    end
  end

  assign spi_sck       = r_sck;
  assign spi_cs_n      = r_cs_n;
  assign spi_si        = r_tx[39];
  assign spi_wp_n      = 1'b1;
  assign spi_reset_n   = r_reset_n;
  assign bus.req_ready = (r_state == StIdle);
  assign bus.busy      = (r_state != StIdle);
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.rsp_last  = r_rsp_last;
  assign bus.done      = r_done;

endmodule

// File: tb/tb_spi_flash_read_ctrl.sv
// Bench for spi_flash_read_ctrl: two instances (CLK_DIV 2 and 1) behind a selector,
// one flash model on the selected pins, and a byte scoreboard on the response port.
module tb_spi_flash_read_ctrl;
  localparam int unsigned CsIdle  = 4;
  localparam int unsigned RstWait = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel       = 1'b0;
  logic        req_valid = 1'b0;
  logic [31:0] req_addr  = '0;
  logic [15:0] req_len   = '0;
  logic        rsp_ready = 1'b1;
  logic        so        = 1'b0;

  spi_flash_read_ctrl_if bus0 ();
  spi_flash_read_ctrl_if bus1 ();
  logic [1:0] sck, cs_n, si, wp_n, reset_n;

  assign bus0.req_valid = req_valid & ~sel;
  assign bus0.req_addr  = req_addr;
  assign bus0.req_len   = req_len;
  assign bus0.rsp_ready = rsp_ready;
  assign bus1.req_valid = req_valid & sel;
  assign bus1.req_addr  = req_addr;
  assign bus1.req_len   = req_len;
  assign bus1.rsp_ready = rsp_ready;

  spi_flash_read_ctrl #(.CLK_DIV(2), .CS_IDLE(CsIdle), .RST_WAIT(RstWait)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0), .spi_sck(sck[0]), .spi_cs_n(cs_n[0]), .spi_si(si[0]),
    .spi_so(so), .spi_wp_n(wp_n[0]), .spi_reset_n(reset_n[0])
  );
  spi_flash_read_ctrl #(.CLK_DIV(1), .CS_IDLE(CsIdle), .RST_WAIT(RstWait)) u_dut1 (
    .clk(clk), .rst(rst), .bus(bus1), .spi_sck(sck[1]), .spi_cs_n(cs_n[1]), .spi_si(si[1]),
    .spi_so(so), .spi_wp_n(wp_n[1]), .spi_reset_n(reset_n[1])
  );

  logic m_sck, m_cs_n, m_si, m_wp_n, m_reset_n;
  logic m_req_ready, m_rsp_valid, m_rsp_last, m_done, m_busy;
  logic [7:0] m_rsp_data;
  assign m_sck       = sel ? sck[1] : sck[0];
  assign m_cs_n      = sel ? cs_n[1] : cs_n[0];
  assign m_si        = sel ? si[1] : si[0];
  assign m_wp_n      = sel ? wp_n[1] : wp_n[0];
  assign m_reset_n   = sel ? reset_n[1] : reset_n[0];
  assign m_req_ready = sel ? bus1.req_ready : bus0.req_ready;
  assign m_rsp_valid = sel ? bus1.rsp_valid : bus0.rsp_valid;
  assign m_rsp_data  = sel ? bus1.rsp_data : bus0.rsp_data;
  assign m_rsp_last  = sel ? bus1.rsp_last : bus0.rsp_last;
  assign m_done      = sel ? bus1.done : bus0.done;
  assign m_busy      = sel ? bus1.busy : bus0.busy;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    logic [7:0] r;
    r = a[7:0] * 8'd37 + a[15:8] + a[23:16] * 8'd3 + a[31:24] * 8'd11 + 8'h5A;
    return r;
  endfunction

  // Flash model: captures command+address on SCK rises, drives SO after SCK falls.
  int unsigned rises    = 0;
  int unsigned cs_falls = 0;
  logic [39:0] cap      = '0;
  logic [7:0]  bfm_b;
  int unsigned bfm_d;
  always @(negedge m_cs_n) begin
    rises = 0;
    cap   = '0;
    cs_falls++;
  end
  always @(posedge m_sck) begin
    if (rises < 40) cap = {cap[38:0], m_si};
    rises++;
  end
  always @(negedge m_sck) begin
    if (!m_cs_n && rises >= 40) begin
      bfm_d = rises - 40;
      bfm_b = mem_byte(cap[31:0] + 32'(bfm_d / 8));
      so    = bfm_b[3'(7 - (bfm_d % 8))];
    end
  end

  typedef struct packed {logic [7:0] data; logic last;} exp_t;
  exp_t sb[$];
  exp_t e_pop;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int unsigned done_cnt = 0, cs_hi_run = 0, last_cs_hi = 0, t_cs = 0, t_first = 0;
  logic seen_first = 1'b0, ready_while_cs = 1'b0, prev_hold = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = '0;

  always @(negedge clk) begin
    if (m_done) done_cnt++;
    if (m_cs_n) begin
      cs_hi_run++;
    end else begin
      if (cs_hi_run != 0) begin
        last_cs_hi = cs_hi_run;
        t_cs       = cyc;
        seen_first = 1'b0;
      end
      cs_hi_run = 0;
    end
    if (m_req_ready && !m_cs_n) ready_while_cs = 1'b1;
    if (m_rsp_valid && !seen_first) begin
      seen_first = 1'b1;
      t_first    = cyc;
    end
    if (prev_hold) chk("rsp_stable", {m_rsp_valid, m_rsp_data, m_rsp_last},
                       {1'b1, prev_data, prev_last});
    prev_hold = rst && m_rsp_valid && !rsp_ready;
    prev_data = m_rsp_data;
    prev_last = m_rsp_last;
    if (m_rsp_valid && rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {m_rsp_data, m_rsp_last}, 9'h0);
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_rsp: got byte %0h with nothing expected", m_rsp_data);
      end else begin
        e_pop = sb.pop_front();
        chk("rsp_byte", {m_rsp_data, m_rsp_last}, e_pop);
      end
    end
  end

  typedef struct {
    logic        sel;
    logic [31:0] addr;
    logic [15:0] len;
    int unsigned stall;
    int unsigned exp_rises;
    int unsigned exp_lat;
  } vec_t;

  task automatic issue(input logic [31:0] addr, input logic [15:0] len);
    logic ok;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = addr;
    req_len   = len;
    ok = 1'b0;
    for (int n = 0; n < 200 && !ok; n++) begin
      @(negedge clk);
      ok = m_req_ready;
    end
    chk("accept_seen", ok, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target);
    logic ok;
    ok = 1'b0;
    for (int n = 0; n < 5000 && !ok; n++) begin
      @(negedge clk);
      ok = (done_cnt >= target);
    end
    chk("done_seen", ok, 1);
  endtask

  task automatic run_vec(input vec_t v);
    int unsigned d0, f0, r1;
    logic got;
    sel       = v.sel;
    rsp_ready = (v.stall == 0);
    for (int i = 0; i < int'(v.len); i++)
      sb.push_back('{data: mem_byte(v.addr + 32'(i)), last: (i == int'(v.len) - 1)});
    d0 = done_cnt;
    f0 = cs_falls;
    issue(v.addr, v.len);
    if (v.len == 0) begin
      @(negedge clk);
      chk("len0_done_pulse", m_done, 1);
      @(negedge clk);
      chk("len0_done_low", m_done, 0);
      repeat (10) @(negedge clk);
      chk("len0_cs_never_low", cs_falls, f0);
      chk("len0_done_count", done_cnt, d0 + 1);
      chk("len0_idle", m_req_ready, 1);
    end else begin
      if (v.stall != 0) begin
        got = 1'b0;
        for (int n = 0; n < 3000 && !got; n++) begin
          @(negedge clk);
          got = m_rsp_valid;
        end
        chk("first_byte_seen", got, 1);
        repeat (40) @(negedge clk);
        r1 = rises;
        chk("hold_sck_high", m_sck, 1);
        repeat (v.stall - 40) @(negedge clk);
        chk("hold_sck_frozen", rises, r1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
      end
      wait_done(d0 + 1);
      repeat (2) @(negedge clk);
      chk("done_single_pulse", done_cnt, d0 + 1);
      chk("sck_rises", rises, v.exp_rises);
      chk("si_cmd", cap[39:32], 8'h13);
      chk("si_addr", cap[31:0], v.addr);
      chk("first_byte_latency", t_first - t_cs, v.exp_lat);
      chk("sb_drained", sb.size(), 0);
      chk("cs_high_after", m_cs_n, 1);
    end
  endtask

  task automatic release_and_check();
    rst = 1'b1;
    for (int k = 1; k <= int'(RstWait); k++) begin
      @(negedge clk);
      if (k == 1) chk("reset_n_released", m_reset_n, 1);
      if (k == int'(RstWait) - 1) chk("ready_before_wait", m_req_ready, 0);
      if (k == int'(RstWait)) chk("ready_after_wait", m_req_ready, 1);
    end
  endtask

  task automatic chk_reset_outputs();
    chk("rst_cs_n", m_cs_n, 1);
    chk("rst_sck", m_sck, 0);
    chk("rst_si", m_si, 0);
    chk("rst_wp_n", m_wp_n, 1);
    chk("rst_reset_n", m_reset_n, 0);
    chk("rst_rsp", {m_rsp_valid, m_rsp_data, m_rsp_last, m_done}, 11'h0);
    chk("rst_busy_ready", {m_busy, m_req_ready}, 2'b10);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[5];
    int unsigned d0, f0;
    logic ok;
    vecs[0] = '{1'b0, 32'h0000_0100, 16'd1,  0,  48,  190};
    vecs[1] = '{1'b0, 32'h03FF_FFFC, 16'd4,  50, 72,  190};
    vecs[2] = '{1'b0, 32'h0000_1234, 16'd0,  0,  0,   0};
    vecs[3] = '{1'b1, 32'h00AB_CDE0, 16'd16, 0,  168, 95};
    vecs[4] = '{1'b0, 32'hFFFF_FFFE, 16'd3,  0,  64,  190};

    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk); #2;
    release_and_check();

    for (int i = 0; i < 5; i++) run_vec(vecs[i]);

    // Back-to-back with req_valid held high.
    sel       = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 2; i++) sb.push_back('{data: mem_byte(32'h2000), last: 1'b1});
    d0 = done_cnt;
    f0 = cs_falls;
    ready_while_cs = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b1;
    req_addr  = 32'h2000;
    req_len   = 16'd1;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      @(negedge clk);
      ok = (cs_falls >= f0 + 2);
    end
    chk("b2b_second_start", ok, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_done(d0 + 2);
    repeat (2) @(negedge clk);
    chk("b2b_cs_high_time", last_cs_hi, CsIdle + 1);
    chk("b2b_ready_only_idle", ready_while_cs, 0);
    chk("b2b_done_count", done_cnt, d0 + 2);
    chk("b2b_sb_drained", sb.size(), 0);

    // Reset in the middle of the address phase.
    f0 = cs_falls;
    issue(32'h0ABC_0000, 16'd4);
    ok = 1'b0;
    for (int n = 0; n < 500 && !ok; n++) begin
      @(negedge clk);
      ok = (cs_falls > f0) && (rises >= 12);
    end
    chk("mid_addr_reached", ok, 1);
    #2 rst = 1'b0;
    #1 chk_reset_outputs();
    @(negedge clk); #2;
    release_and_check();

    run_vec(vecs[0]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
